// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, the result stage and writeback/PC-select.
// The upstream (in_*) and downstream (out_*) sides share one interface instance.
interface alu_result_stage_if #(
  parameter int WIDTH = 64,
  parameter int RA_W  = 5
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_result;
  logic             in_overflow;
  logic             in_zero;
  logic             in_equal;
  logic             in_less;
  logic [RA_W-1:0]  in_rd;
  logic             in_we;
  logic [2:0]       in_br;
  logic [WIDTH-1:0] in_target;

  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_result;
  logic [RA_W-1:0]  out_rd;
  logic             out_we;
  logic             out_taken;
  logic [WIDTH-1:0] out_target;
  logic             out_overflow;
  logic             out_zero;

  modport master (
    output in_valid, in_result, in_overflow, in_zero, in_equal, in_less,
           in_rd, in_we, in_br, in_target, out_ready,
    input  in_ready, out_valid, out_result, out_rd, out_we, out_taken,
           out_target, out_overflow, out_zero
  );

  modport slave (
    input  in_valid, in_result, in_overflow, in_zero, in_equal, in_less,
           in_rd, in_we, in_br, in_target, out_ready,
    output in_ready, out_valid, out_result, out_rd, out_we, out_taken,
           out_target, out_overflow, out_zero
  );
endinterface

// File: rtl/alu_result_stage.sv
// ALU result register stage: resolves branches, buffers up to two entries
// (main + skid) behind a registered in_ready, and counts taken branches.
module alu_result_stage #(
  parameter int WIDTH = 64,
  parameter int RA_W  = 5,
  parameter int CNT_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  alu_result_stage_if.slave  bus,
  output logic [CNT_W-1:0]   taken_count
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] target;
    logic [RA_W-1:0]  rd;
    logic             we;
    logic             taken;
    logic             overflow;
    logic             zero;
  } entry_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  entry_t           in_entry;
  entry_t           main_q, main_d;
  entry_t           skid_q, skid_d;
  logic             main_vld_q, main_vld_d;
  logic             skid_vld_q, skid_vld_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             br_taken;
  logic             accept;
  logic             deliver;

  always_comb begin
    br_taken = 1'b0;
    case (bus.in_br)
      3'd1:    br_taken = bus.in_equal;
      3'd2:    br_taken = !bus.in_equal;
      3'd3:    br_taken = bus.in_less;
      3'd4:    br_taken = !bus.in_less;
      3'd5:    br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

  always_comb begin
    in_entry          = '0;
    in_entry.result   = bus.in_result;
    in_entry.target   = bus.in_target;
    in_entry.rd       = bus.in_rd;
    in_entry.we       = bus.in_we && (bus.in_rd != '0);
    in_entry.taken    = br_taken;
    in_entry.overflow = bus.in_overflow;
    in_entry.zero     = bus.in_zero;
  end

  // in_ready is !skid_vld_q, so an accept never coincides with a full skid.
  assign accept  = bus.in_valid && !skid_vld_q;
  assign deliver = main_vld_q && bus.out_ready;

  always_comb begin
    main_d     = main_q;
    main_vld_d = main_vld_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    if (flush) begin
      main_vld_d = 1'b0;
      skid_vld_d = 1'b0;
    end else if (!main_vld_q || bus.out_ready) begin
      if (skid_vld_q) begin
        main_d     = skid_q;
        main_vld_d = 1'b1;
        skid_vld_d = 1'b0;
      end else if (accept) begin
        main_d     = in_entry;
        main_vld_d = 1'b1;
      end else begin
        main_vld_d = 1'b0;
      end
    end else if (accept) begin
      skid_d     = in_entry;
      skid_vld_d = 1'b1;
    end
  end

  // Deliveries in a flush cycle still count; flush never clears the counter.
  always_comb begin
    cnt_d = cnt_q;
    if (deliver && main_q.taken && (cnt_q != '1)) cnt_d = cnt_q + CNT_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_q     <= '0;
      skid_q     <= '0;
      main_vld_q <= 1'b0;
      skid_vld_q <= 1'b0;
      cnt_q      <= '0;
    end else begin
      main_q     <= main_d;
      skid_q     <= skid_d;
      main_vld_q <= main_vld_d;
      skid_vld_q <= skid_vld_d;
      cnt_q      <= cnt_d;
    end
  end

  assign bus.in_ready     = !skid_vld_q;
  assign bus.out_valid    = main_vld_q;
  assign bus.out_result   = main_q.result;
  assign bus.out_rd       = main_q.rd;
  assign bus.out_we       = main_q.we;
  assign bus.out_taken    = main_q.taken;
  assign bus.out_target   = main_q.target;
  assign bus.out_overflow = main_q.overflow;
  assign bus.out_zero     = main_q.zero;
  assign taken_count      = cnt_q;

endmodule

// File: tb/tb_alu_result_stage.sv
// Bench for alu_result_stage: directed scenarios plus random traffic, all
// compared against a FIFO-of-entries reference model of the stage.
module tb_alu_result_stage;
  localparam int W  = 64;
  localparam int RA = 5;
  localparam int CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          flush = 1'b0;
  logic [CW-1:0] taken_count;

  alu_result_stage_if #(.WIDTH(W), .RA_W(RA)) bus ();

  alu_result_stage #(.WIDTH(W), .RA_W(RA), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .bus         (bus.slave),
    .taken_count (taken_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  result;
    logic [W-1:0]  target;
    logic [RA-1:0] rd;
    logic          we;
    logic          taken;
    logic          ovf;
    logic          zero;
  } ent_t;

  ent_t q[$];
  int   mcnt = 0;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic exp_taken(input logic [2:0] br, input logic eq, input logic lt);
    if (br == 3'd1) return eq;
    if (br == 3'd2) return !eq;
    if (br == 3'd3) return lt;
    if (br == 3'd4) return !lt;
    if (br == 3'd5) return 1'b1;
    return 1'b0;
  endfunction

  task automatic compare_all();
    check("in_ready", bus.in_ready, q.size() < 2);
    check("out_valid", bus.out_valid, q.size() > 0);
    if (q.size() > 0) begin
      check("out_result", bus.out_result, q[0].result);
      check("out_target", bus.out_target, q[0].target);
      check("out_rd", bus.out_rd, q[0].rd);
      check("out_we", bus.out_we, q[0].we);
      check("out_taken", bus.out_taken, q[0].taken);
      check("out_overflow", bus.out_overflow, q[0].ovf);
      check("out_zero", bus.out_zero, q[0].zero);
    end
    check("taken_count", taken_count, mcnt);
  endtask

  // One clock: predict from pre-edge inputs, advance the model, then compare.
  task automatic step();
    bit   acc, dlv;
    ent_t e;
    acc = bus.in_valid && (q.size() < 2);
    dlv = (q.size() > 0) && bus.out_ready;
    e.result = bus.in_result;
    e.target = bus.in_target;
    e.rd     = bus.in_rd;
    e.we     = bus.in_we && (bus.in_rd != 0);
    e.taken  = exp_taken(bus.in_br, bus.in_equal, bus.in_less);
    e.ovf    = bus.in_overflow;
    e.zero   = bus.in_zero;
    @(posedge clk);
    if (dlv && q[0].taken && mcnt < CNT_MAX) mcnt++;
    if (flush) q.delete();
    else begin
      if (dlv) void'(q.pop_front());
      if (acc) q.push_back(e);
    end
    #1;
    compare_all();
  endtask

  task automatic drive(input bit v, input logic [63:0] res, input logic [2:0] br,
                       input bit eq, input bit lt, input logic [4:0] rd,
                       input bit we, input logic [63:0] tgt);
    bus.in_valid    = v;
    bus.in_result   = res;
    bus.in_br       = br;
    bus.in_equal    = eq;
    bus.in_less     = lt;
    bus.in_rd       = rd;
    bus.in_we       = we;
    bus.in_target   = tgt;
    bus.in_overflow = 1'($urandom_range(0, 1));
    bus.in_zero     = 1'($urandom_range(0, 1));
  endtask

  task automatic idle();
    drive(0, 64'h0, 3'd0, 0, 0, 5'd0, 0, 64'h0);
  endtask

  // Asserts reset away from a clock edge and checks the asynchronous clear.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("rst in_ready", bus.in_ready, 1);
    check("rst out_valid", bus.out_valid, 0);
    check("rst out_result", bus.out_result, 0);
    check("rst out_rd", bus.out_rd, 0);
    check("rst out_we", bus.out_we, 0);
    check("rst out_taken", bus.out_taken, 0);
    check("rst out_target", bus.out_target, 0);
    check("rst out_overflow", bus.out_overflow, 0);
    check("rst out_zero", bus.out_zero, 0);
    check("rst taken_count", taken_count, 0);
    q.delete();
    mcnt = 0;
    idle();
    flush = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    logic [2:0] br_tab [6];
    bit         eq_tab [6];
    bit         lt_tab [6];
    bit         tk_tab [6];

    idle();
    bus.out_ready = 1'b0;
    #2;
    do_reset();

    // Streaming
    bus.out_ready = 1'b1;
    drive(1, 64'h10, 3'd0, 0, 0, 5'd1, 1, 64'h0); step(); check("stream r0", bus.out_result, 64'h10);
    drive(1, 64'h20, 3'd0, 0, 0, 5'd2, 1, 64'h0); step(); check("stream r1", bus.out_result, 64'h20);
    check("stream ready", bus.in_ready, 1);
    drive(1, 64'h30, 3'd0, 0, 0, 5'd3, 1, 64'h0); step(); check("stream r2", bus.out_result, 64'h30);
    idle(); step();

    // Back-pressure: A held on outputs, B parked in skid
    bus.out_ready = 1'b0;
    drive(1, 64'h1, 3'd0, 0, 0, 5'd4, 1, 64'h0); step();
    drive(1, 64'h2, 3'd0, 0, 0, 5'd4, 1, 64'h0); step();
    check("bp in_ready", bus.in_ready, 0);
    check("bp hold A", bus.out_result, 64'h1);
    idle(); step();
    check("bp still A", bus.out_result, 64'h1);
    bus.out_ready = 1'b1;
    step(); check("bp then B", bus.out_result, 64'h2);
    step(); check("bp drained", bus.out_valid, 0);
    check("bp ready back", bus.in_ready, 1);

    // Branch decode table: br, equal, less -> taken
    br_tab = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd7};
    eq_tab = '{1, 1, 0, 0, 0, 1};
    lt_tab = '{0, 0, 1, 1, 0, 1};
    tk_tab = '{1, 0, 1, 0, 1, 0};
    for (int i = 0; i < 6; i++) begin
      drive(1, 64'(i), br_tab[i], eq_tab[i], lt_tab[i], 5'd7, 1, 64'h8000_0040);
      step();
      check("br taken", bus.out_taken, tk_tab[i]);
      check("br target", bus.out_target, 64'h8000_0040);
    end

    // x0 write suppression
    drive(1, 64'hAA, 3'd0, 0, 0, 5'd0, 1, 64'h0); step(); check("x0 we", bus.out_we, 0);
    drive(1, 64'hBB, 3'd0, 0, 0, 5'd5, 1, 64'h0); step(); check("x5 we", bus.out_we, 1);
    idle(); step();

    // Flush with both entries full and an input offered
    bus.out_ready = 1'b0;
    drive(1, 64'hC1, 3'd5, 0, 0, 5'd1, 1, 64'h0); step();
    drive(1, 64'hC2, 3'd5, 0, 0, 5'd2, 1, 64'h0); step();
    drive(1, 64'hC3, 3'd5, 0, 0, 5'd3, 1, 64'h0);
    flush = 1'b1; step(); flush = 1'b0;
    check("flush out_valid", bus.out_valid, 0);
    check("flush in_ready", bus.in_ready, 1);
    idle(); bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) step();

    // Random traffic with occasional flush
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 3) != 0, {$urandom, $urandom}, 3'($urandom_range(0, 7)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
            1'($urandom_range(0, 1)), {$urandom, $urandom});
      bus.out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 15) == 0;
      step();
    end
    flush = 1'b0;

    // Counter saturation then reset mid-stream
    idle(); bus.out_ready = 1'b1; step();
    do_reset();
    for (int i = 0; i < 17; i++) begin
      drive(1, 64'(i), 3'd5, 0, 0, 5'd1, 1, 64'h100);
      step();
    end
    drive(1, 64'h55, 3'd0, 0, 0, 5'd1, 1, 64'h0);
    step();
    check("sat count", taken_count, 4'hF);
    check("sat midstream valid", bus.out_valid, 1);
    do_reset();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Pipeline stage directly downstream of the 64-bit ALU. Captures the ALU result and status flags together with destination-register and branch-kind sidebands.
- Resolves the branch decision from the flags and presents a registered result to writeback/PC-select over a valid/ready handshake.
- Internal 2-entry skid buffer keeps full throughput under back-pressure with a registered in_ready. Also provides synchronous flush and a saturating taken-branch counter.

Parameters:
- WIDTH, 64: data width of result and target.
- RA_W, 5: destination register address width.
- CNT_W, 32: taken-branch counter width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous; discards all buffered and in-flight entries.
- in_valid  input  1  upstream entry valid.
- in_ready  output  1  stage can accept; registered, equals !skid_valid.
- in_result  input  WIDTH  ALU result.
- in_overflow, in_zero, in_equal, in_less  input  1 each  ALU status flags.
- in_rd  input  RA_W  destination register.
- in_we  input  1  register write request.
- in_br  input  3  branch kind: 0 NONE, 1 BEQ, 2 BNE, 3 BLT, 4 BGE, 5 JUMP; 6–7 treated as NONE.
- in_target  input  WIDTH  branch target address.
- out_valid  output  1  output entry valid.
- out_ready  input  1  downstream accepts.
- out_result  output  WIDTH  registered result.
- out_rd  output  RA_W  destination register.
- out_we  output  1  write enable, forced 0 when rd==0.
- out_taken  output  1  branch resolved taken.
- out_target  output  WIDTH  target, passed through unchanged.
- out_overflow  output  1  latched overflow flag.
- out_zero  output  1  latched zero flag.
- taken_count  output  CNT_W  count of taken branches delivered.

Behaviour:
- Reset (rst_n low, async):
  - out_valid=0, skid_valid=0, in_ready=1.
  - out_result, out_rd, out_we, out_taken, out_target, out_overflow, out_zero and taken_count all 0.
- Branch resolution is computed on the input side and stored with the entry:
  - BEQ: taken=in_equal.
  - BNE: taken=!in_equal.
  - BLT: taken=in_less.
  - BGE: taken=!in_less.
  - JUMP: taken=1.
  - NONE or codes 6–7: taken=0.
- Write-enable rule: stored we = in_we & (in_rd != 0).
- Handshakes:
  - Accept when in_valid & in_ready.
  - Deliver when out_valid & out_ready.
- Main register (drives outputs) loads when !out_valid or out_ready, in this priority:
  - from skid if skid_valid;
  - otherwise from input if accepted;
  - otherwise out_valid goes to 0.
- Skid register loads when an input is accepted while out_valid & !out_ready.
- Latency: 1 cycle. An entry accepted at edge N is visible on the outputs after edge N.
- Throughput: 1 entry/cycle while out_ready=1.
- Ordering: strictly FIFO. The skid entry always leaves before any newer entry.
- Output stability: while out_valid & !out_ready, every out_* field holds stable.
- Flush:
  - At the next edge, out_valid=0 and skid_valid=0.
  - An input accepted in the flush cycle is dropped.
  - A delivery in the flush cycle still counts toward taken_count.
  - Data fields may hold stale values.
- taken_count:
  - +1 on each delivery with out_taken=1.
  - Saturates at all-ones.
  - Not affected by flush; cleared only by reset.
- Reset mid-operation: all entries are lost immediately. in_ready returns to 1 asynchronously.

Test Plan:
- Streaming: out_ready=1, send results 0x10, 0x20, 0x30 on consecutive cycles -> they appear on out_result in order, one cycle later each; in_ready stays 1.
- Back-pressure:
  - Send A=0x1 and B=0x2 while out_ready=0 -> A held on out_*, B in skid, in_ready=0 after the second edge.
  - Raise out_ready -> A, then B, then out_valid=0; in_ready returns to 1.
- Branch decode:
  - BEQ with equal=1 -> taken=1; BNE with equal=1 -> 0.
  - BLT with less=1 -> 1; BGE with less=1 -> 0.
  - JUMP -> 1; code 7 -> 0.
  - Target 0x8000_0040 passes through unchanged.
- x0 write: in_rd=0, in_we=1 -> out_we=0; in_rd=5, in_we=1 -> out_we=1.
- Flush with both entries full and a simultaneous input -> out_valid=0 and in_ready=1 next cycle; no stale entry is ever delivered afterwards.
- Counter saturation: CNT_W=4, deliver 17 taken branches -> taken_count=0xF. Then assert rst_n=0 mid-stream -> all outputs 0 asynchronously.
